// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register specifiers, datapath width.
package y86_pkg;

  localparam int DATA_W = 64;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

endpackage

// File: rtl/y86_regfile.sv
// Program register file: two combinational read ports, two write ports (M beats E).
// DECODE_WB_BYPASS_EN adds same-cycle write-through forwarding onto the read ports.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int                DW        = 64,
  parameter int                NREGS     = 15,
  parameter logic [DW-1:0]     RSP_RESET = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [3:0]    dst_e_i,
  input  logic [DW-1:0] val_e_i,
  input  logic [3:0]    dst_m_i,
  input  logic [DW-1:0] val_m_i,
  input  logic [3:0]    src_a_i,
  input  logic [3:0]    src_b_i,
  output logic [DW-1:0] val_a_o,
  output logic [DW-1:0] val_b_o
);

  logic [DW-1:0] regs_q [NREGS];
  logic          we_e_d;
  logic          we_m_d;

  assign we_e_d = wr_en_i && (dst_e_i != REG_NONE) && (32'(dst_e_i) < NREGS);
  assign we_m_d = wr_en_i && (dst_m_i != REG_NONE) && (32'(dst_m_i) < NREGS);

  // M port is written last so it wins when both target the same register (popq %rsp)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == int'(REG_RSP)) ? RSP_RESET : '0;
      end
    end else begin
      if (we_e_d) regs_q[dst_e_i] <= val_e_i;
      if (we_m_d) regs_q[dst_m_i] <= val_m_i;
    end
  end

  function automatic logic [DW-1:0] rd(input logic [3:0] s);
    logic [DW-1:0] v;
    v = '0;
    if ((s != REG_NONE) && (32'(s) < NREGS)) begin
      v = regs_q[s];
`ifdef DECODE_WB_BYPASS_EN
      if (we_m_d && (s == dst_m_i)) v = val_m_i;
      else if (we_e_d && (s == dst_e_i)) v = val_e_i;
`endif
    end
    return v;
  endfunction

  assign val_a_o = rd(src_a_i);
  assign val_b_o = rd(src_b_i);

endmodule

// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode/writeback stage: register specifier decode plus the register file.
// Optional DECODE_WB_BYPASS_EN enables same-cycle forwarding inside the register file.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                NREGS     = 15,
  parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic              instr_err
);

  always_comb begin
    srcA      = REG_NONE;
    srcB      = REG_NONE;
    dstE      = REG_NONE;
    dstM      = REG_NONE;
    instr_err = (icode > I_POPQ);
    case (icode)
      I_RRMOVQ: begin
        srcA = rA;
        dstE = cnd ? rB : REG_NONE;
      end
      I_IRMOVQ: dstE = rB;
      I_RMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      I_MRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      I_OPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      I_CALL: begin
        srcB = REG_RSP;
        dstE = REG_RSP;
      end
      I_RET: begin
        srcA = REG_RSP;
        srcB = REG_RSP;
        dstE = REG_RSP;
      end
      I_PUSHQ: begin
        srcA = rA;
        srcB = REG_RSP;
        dstE = REG_RSP;
      end
      I_POPQ: begin
        srcA = REG_RSP;
        srcB = REG_RSP;
        dstE = REG_RSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  // Invalid instructions decode to NONE everywhere; the explicit gate keeps them write-free
  y86_regfile #(
    .DW        (DATA_W),
    .NREGS     (NREGS),
    .RSP_RESET (RSP_RESET)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (wb_en && !instr_err),
    .dst_e_i (dstE),
    .val_e_i (valE),
    .dst_m_i (dstM),
    .val_m_i (valM),
    .src_a_i (srcA),
    .src_b_i (srcB),
    .val_a_o (valA),
    .val_b_o (valB)
  );

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed scenarios plus randomized instructions against a table-driven model.
module tb_decode_writeback;

  localparam logic [63:0] RSP_RST = 64'h200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  icode = '0, rA = '0, rB = '0;
  logic        cnd = 1'b0, wb_en = 1'b0;
  logic [63:0] valE = '0, valM = '0;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB;
  logic        instr_err;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mregs [15];

  decode_writeback #(
    .DATA_W    (64),
    .NREGS     (15),
    .RSP_RESET (RSP_RST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .icode     (icode),
    .rA        (rA),
    .rB        (rB),
    .cnd       (cnd),
    .wb_en     (wb_en),
    .valE      (valE),
    .valM      (valM),
    .srcA      (srcA),
    .srcB      (srcB),
    .dstE      (dstE),
    .dstM      (dstM),
    .valA      (valA),
    .valB      (valB),
    .instr_err (instr_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (ic inside {4'h3, 4'h6}) return rb;
    if (ic == 4'h2) return c ? rb : 4'hF;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] s);
    logic [3:0] de, dm;
    de = m_dstE(icode, rB, cnd);
    dm = m_dstM(icode, rA);
    if (s == 4'hF) return 64'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && (icode <= 4'hB) && !rst) begin
      if (dm != 4'hF && s == dm) return valM;
      if (de != 4'hF && s == de) return valE;
    end
`endif
    return mregs[s];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 15; i++) mregs[i] = (i == 4) ? RSP_RST : 64'h0;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic we, input logic [63:0] ve, input logic [63:0] vm);
    icode = ic; rA = ra; rB = rb; cnd = c; wb_en = we; valE = ve; valM = vm;
    #1;
  endtask

  // Advance one edge and commit the architectural effect of the current inputs to the model
  task automatic clock();
    logic [3:0] de, dm;
    @(posedge clk);
    #1;
    de = m_dstE(icode, rB, cnd);
    dm = m_dstM(icode, rA);
    if (!rst && wb_en && icode <= 4'hB) begin
      if (de != 4'hF) mregs[de] = valE;
      if (dm != 4'hF) mregs[dm] = valM;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset_initial();
    rst = 1'b1;
    m_reset();
    drive(4'h6, 4'h3, 4'h4, 1'b0, 1'b0, 64'h0, 64'h0);
    vectors++;
    if (valA !== 64'h0) begin
      miscompares++; $display("FAIL reset_init_valA: got %h expected %h", valA, 64'h0);
    end
    vectors++;
    if (valB !== RSP_RST) begin
      miscompares++; $display("FAIL reset_init_rsp: got %h expected %h", valB, RSP_RST);
    end
    clock();
    rst = 1'b0;
  endtask

  task automatic test_reset_midrun();
    drive(4'h3, 4'h0, 4'h3, 1'b0, 1'b1, 64'h55, 64'h0);
    clock();
    drive(4'h6, 4'h3, 4'h4, 1'b0, 1'b0, 64'h0, 64'h0);
    vectors++;
    if (valA !== 64'h55) begin
      miscompares++; $display("FAIL reset_prewrite: got %h expected %h", valA, 64'h55);
    end
    rst = 1'b1;
    m_reset();
    #1;
    vectors++;
    if (valA !== 64'h0) begin
      miscompares++; $display("FAIL reset_async_r3: got %h expected %h", valA, 64'h0);
    end
    vectors++;
    if (valB !== RSP_RST) begin
      miscompares++; $display("FAIL reset_async_rsp: got %h expected %h", valB, RSP_RST);
    end
    vectors++;
    if (srcA !== 4'h3 || dstE !== 4'h4) begin
      miscompares++; $display("FAIL reset_decode_live: got srcA=%h dstE=%h expected 3 4", srcA, dstE);
    end
    drive(4'h3, 4'h0, 4'h3, 1'b0, 1'b1, 64'h99, 64'h0);
    clock();
    rst = 1'b0;
    drive(4'h6, 4'h3, 4'h4, 1'b0, 1'b0, 64'h0, 64'h0);
    vectors++;
    if (valA !== 64'h0) begin
      miscompares++; $display("FAIL reset_edge_ignored: got %h expected %h", valA, 64'h0);
    end
  endtask

  task automatic test_irmovq();
    drive(4'h3, 4'hF, 4'h2, 1'b0, 1'b1, 64'hDEADBEEF, 64'h0);
    vectors++;
    if (dstE !== 4'h2 || srcA !== 4'hF || srcB !== 4'hF || dstM !== 4'hF) begin
      miscompares++;
      $display("FAIL irmovq_decode: got dstE=%h srcA=%h srcB=%h dstM=%h expected 2 f f f", dstE, srcA, srcB, dstM);
    end
    clock();
    drive(4'h6, 4'h2, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    vectors++;
    if (valA !== 64'hDEADBEEF) begin
      miscompares++; $display("FAIL irmovq_read: got %h expected %h", valA, 64'hDEADBEEF);
    end
  endtask

  task automatic test_cmov();
    drive(4'h2, 4'h1, 4'h5, 1'b0, 1'b1, 64'hAB, 64'h0);
    vectors++;
    if (dstE !== 4'hF) begin
      miscompares++; $display("FAIL cmov_nottaken_dst: got %h expected f", dstE);
    end
    clock();
    drive(4'h6, 4'h5, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    vectors++;
    if (valA !== 64'h0) begin
      miscompares++; $display("FAIL cmov_nottaken_reg: got %h expected %h", valA, 64'h0);
    end
    drive(4'h2, 4'h1, 4'h5, 1'b1, 1'b1, 64'hAB, 64'h0);
    vectors++;
    if (dstE !== 4'h5) begin
      miscompares++; $display("FAIL cmov_taken_dst: got %h expected 5", dstE);
    end
    clock();
    drive(4'h6, 4'h5, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    vectors++;
    if (valA !== 64'hAB) begin
      miscompares++; $display("FAIL cmov_taken_reg: got %h expected %h", valA, 64'hAB);
    end
  endtask

  task automatic test_popq_rsp();
    drive(4'hB, 4'h4, 4'hF, 1'b0, 1'b1, 64'h208, 64'h1234);
    vectors++;
    if (srcA !== 4'h4 || srcB !== 4'h4 || dstE !== 4'h4 || dstM !== 4'h4) begin
      miscompares++;
      $display("FAIL popq_decode: got srcA=%h srcB=%h dstE=%h dstM=%h expected 4 4 4 4", srcA, srcB, dstE, dstM);
    end
    clock();
    drive(4'h6, 4'h4, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    vectors++;
    if (valA !== 64'h1234) begin
      miscompares++; $display("FAIL popq_m_wins: got %h expected %h", valA, 64'h1234);
    end
  endtask

  task automatic test_no_write();
    drive(4'hC, 4'h1, 4'h2, 1'b1, 1'b1, 64'hFF, 64'hFF);
    vectors++;
    if (instr_err !== 1'b1 || srcA !== 4'hF || srcB !== 4'hF || dstE !== 4'hF || dstM !== 4'hF) begin
      miscompares++;
      $display("FAIL invalid_decode: got err=%b srcA=%h srcB=%h dstE=%h dstM=%h expected 1 f f f f",
               instr_err, srcA, srcB, dstE, dstM);
    end
    clock();
    drive(4'h3, 4'h0, 4'h7, 1'b0, 1'b0, 64'h5A5A, 64'h0);
    clock();
    for (int i = 0; i < 15; i += 2) begin
      drive(4'h6, 4'(i), 4'(i + 1), 1'b0, 1'b0, 64'h0, 64'h0);
      vectors++;
      if (valA !== mregs[i] || valB !== m_read(4'(i + 1))) begin
        miscompares++;
        $display("FAIL no_write_r%0d: got %h/%h expected %h/%h", i, valA, valB, mregs[i], m_read(4'(i + 1)));
      end
      clock();
    end
  endtask

  task automatic test_bypass();
    logic [63:0] exp;
    drive(4'h6, 4'h6, 4'h6, 1'b0, 1'b1, 64'h77, 64'h0);
`ifdef DECODE_WB_BYPASS_EN
    exp = 64'h77;
`else
    exp = mregs[6];
`endif
    vectors++;
    if (valA !== exp) begin
      miscompares++; $display("FAIL bypass_same_cycle: got %h expected %h", valA, exp);
    end
    clock();
    drive(4'h6, 4'h6, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    vectors++;
    if (valA !== 64'h77) begin
      miscompares++; $display("FAIL bypass_next_cycle: got %h expected %h", valA, 64'h77);
    end
  endtask

  task automatic test_random();
    logic [63:0] ea, eb;
    for (int n = 0; n < 300; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom});
      ea = m_read(m_srcA(icode, rA));
      eb = m_read(m_srcB(icode, rB));
      vectors++;
      if (srcA !== m_srcA(icode, rA) || srcB !== m_srcB(icode, rB) ||
          dstE !== m_dstE(icode, rB, cnd) || dstM !== m_dstM(icode, rA) ||
          instr_err !== (icode > 4'hB)) begin
        miscompares++;
        $display("FAIL rand_decode[%0d]: ic=%h got %h %h %h %h %b expected %h %h %h %h %b", n, icode,
                 srcA, srcB, dstE, dstM, instr_err, m_srcA(icode, rA), m_srcB(icode, rB),
                 m_dstE(icode, rB, cnd), m_dstM(icode, rA), icode > 4'hB);
      end
      vectors++;
      if (valA !== ea || valB !== eb) begin
        miscompares++;
        $display("FAIL rand_read[%0d]: got %h/%h expected %h/%h", n, valA, valB, ea, eb);
      end
      clock();
    end
  endtask

  initial begin
    m_reset();
    #2;
    test_reset_initial();
    test_irmovq();
    test_cmov();
    test_popq_rsp();
    test_no_write();
    test_bypass();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
